spi_block_sequencer: RTL and testbench
======================================

// Module: spi_block_sequencer
// PURPOSE
//  Sits directly upstream of the SPI byte master. Accepts one 128-bit AES block and
//  serialises it into NUM_BYTES byte transfers using the master's start/tx/done handshake.
//  Collects each returned rx byte into a 128-bit response block.
//  Enforces an inter-byte gap and a per-byte timeout. Raises an error on a stalled transfer.
// PARAMETERS
//  NUM_BYTES   16   bytes per block; block width = 8*NUM_BYTES
//  GAP_CYCLES  2    idle clk cycles between spi_done and the next spi_start (0 allowed)
//  TIMEOUT     1024 max clk cycles from spi_start to spi_done before abort (>=2)
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      asynchronous, active-high reset
//  blk_valid    in   1      upstream block available
//  blk_data     in   8*NB   block to send; byte 0 = blk_data[8*NB-1 -: 8]
//  blk_ready    out  1      high only in IDLE; transfer on blk_valid & blk_ready
//  rsp_valid    out  1      response block available; held until rsp_ready
//  rsp_data     out  8*NB   received bytes; first received byte in MSBs
//  rsp_ready    in   1      downstream accepts response
//  spi_start    out  1      one-cycle pulse to SPI master
//  spi_tx       out  8      byte to send; stable from spi_start until spi_done
//  spi_rx       in   8      byte received; valid in the cycle spi_done is high
//  spi_done     in   1      one-cycle pulse from SPI master, byte complete
//  busy         out  1      high in every state except IDLE
//  err_timeout  out  1      sticky; set on timeout; cleared by next accepted block
// BEHAVIOUR
//  Reset: state=IDLE; blk_ready=1; rsp_valid=0; rsp_data=0; spi_start=0; spi_tx=0;
//   busy=0; err_timeout=0; byte index and counters=0.
//  FSM: IDLE -> START -> WAIT -> GAP -> START ... -> RESP -> IDLE.
//  IDLE: on blk_valid&blk_ready, latch blk_data into the tx shift register.
//   Clear err_timeout and the byte index. Go to START on the next cycle.
//  START: drive spi_tx = current MSB byte. Assert spi_start for exactly 1 cycle.
//   Clear the timeout counter. Go to WAIT.
//  WAIT: the timeout counter increments each cycle.
//   On spi_done: shift spi_rx into the LSB end of rsp shift register (shift left 8).
//   In the same cycle, shift the tx register left 8 and increment the byte index.
//   If index was NUM_BYTES-1 go to RESP, else go to GAP.
//   If the counter reaches TIMEOUT-1 without spi_done: set err_timeout.
//   Then go to RESP with partial data. Unfilled low bytes read 0.
//  GAP: wait GAP_CYCLES cycles, then go to START. With GAP_CYCLES=0, go straight to START.
//   Minimum spacing spi_done->spi_start is therefore GAP_CYCLES+1.
//  RESP: rsp_valid=1 and rsp_data stable. On rsp_ready go to IDLE.
//   rsp_valid drops the cycle after acceptance.
//  spi_done outside WAIT is ignored: no data capture and no state change.
//  Latency with GAP_CYCLES=G and master byte time T cycles (start->done):
//   accept -> rsp_valid = NUM_BYTES*(T+1+G) - G + 2 cycles.
//  Reset asserted mid-block: immediate return to reset values. The partial block is discarded.
//   No spi_start is issued until a new block is accepted.
//  blk_valid while busy: not accepted (blk_ready=0). Upstream must hold data.
//  Counter widths: index clog2(NUM_BYTES+1), timeout clog2(TIMEOUT), gap clog2(GAP_CYCLES+1).
// TESTING
//  1 Block 0x000102..0F, loopback model (rx=tx, T=16) -> 16 spi_start pulses.
//    spi_tx sequence 00..0F; rsp_data == blk_data; err_timeout=0.
//  2 Check spacing -> exactly GAP_CYCLES+1 cycles between each spi_done and next spi_start.
//    Also check the latency formula, for both GAP_CYCLES=2 and 0.
//  3 Model never returns done on byte 5 -> err_timeout=1 after TIMEOUT cycles.
//    rsp_data holds bytes 0..4 in MSBs, rest 0.
//    Next accepted block clears err_timeout.
//  4 rsp_ready held low 50 cycles -> rsp_valid and rsp_data stable, blk_ready=0, no spi_start.
//  5 rst pulsed while in WAIT of byte 7 -> all outputs at reset values.
//    A new block restarts from byte 0.
//  6 Spurious spi_done pulses in IDLE and GAP, and blk_valid while busy -> no state change.
//    No capture, and the busy block completes correctly.

Source files
------------

// File: rtl/spi_block_sequencer_if.sv
// spi_block_sequencer_if
//   Bundles the block-side handshake, response-side handshake, SPI byte master
//   handshake and status signals of the block sequencer.
//   master : view of the sequencer itself (drives ready/response/spi_start/spi_tx/status)
//   slave  : view of the surrounding logic (block source, response sink, SPI byte master)
//   Signals:
//     blk_valid/blk_data/blk_ready   block in, byte 0 in the MSBs
//     rsp_valid/rsp_data/rsp_ready   response out, first received byte in the MSBs
//     spi_start/spi_tx               byte request to the SPI master
//     spi_rx/spi_done                byte completion from the SPI master
//     busy/err_timeout               status
interface spi_block_sequencer_if #(
  parameter int unsigned NUM_BYTES = 16
);
  logic                     blk_valid;
  logic [8*NUM_BYTES-1:0]   blk_data;
  logic                     blk_ready;
  logic                     rsp_valid;
  logic [8*NUM_BYTES-1:0]   rsp_data;
  logic                     rsp_ready;
  logic                     spi_start;
  logic [7:0]               spi_tx;
  logic [7:0]               spi_rx;
  logic                     spi_done;
  logic                     busy;
  logic                     err_timeout;

  modport master (
    input  blk_valid, blk_data, rsp_ready, spi_rx, spi_done,
    output blk_ready, rsp_valid, rsp_data, spi_start, spi_tx, busy, err_timeout
  );

  modport slave (
    output blk_valid, blk_data, rsp_ready, spi_rx, spi_done,
    input  blk_ready, rsp_valid, rsp_data, spi_start, spi_tx, busy, err_timeout
  );
endinterface

// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer
//   Takes one NUM_BYTES-byte block, feeds it MSB byte first to an SPI byte master
//   through its start/tx/done handshake, and gathers the returned bytes into a
//   response block (first returned byte in the MSBs). Inserts GAP_CYCLES idle
//   cycles after every byte and aborts a byte that takes longer than TIMEOUT
//   cycles, returning the partial block with the unfilled low bytes at zero and
//   err_timeout set until the next block is accepted.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  spi_block_sequencer_if.master (block, response, SPI and status signals)
module spi_block_sequencer #(
  parameter int unsigned NUM_BYTES  = 16,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                   clk,
  input logic                   rst,
  spi_block_sequencer_if.master bus
);

  localparam int unsigned BlkW = 8 * NUM_BYTES;
  localparam int unsigned IdxW = $clog2(NUM_BYTES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT);
  // A zero-cycle gap still needs a legal (unused) 1-bit counter.
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StGap,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [BlkW-1:0] tx_q, tx_d;
  logic [BlkW-1:0] rsp_q, rsp_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rsp_q     <= '0;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rsp_q     <= rsp_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rsp_d     = rsp_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        // blk_ready is high in this state, so blk_valid alone means accept.
        if (bus.blk_valid) begin
          tx_d    = bus.blk_data;
          rsp_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end

      StWait: begin
        if (bus.spi_done) begin
          // Writing the byte at its final position equals shifting it in from
          // the LSB end for a full block, and leaves a partial block MSB-aligned.
          for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IdxW'(i)) begin
              rsp_d[8*(NUM_BYTES-1-i) +: 8] = bus.spi_rx;
            end
          end
          tx_d  = {tx_q[BlkW-9:0], 8'h00};
          idx_d = idx_q + 1'b1;
          if (idx_q == IdxW'(NUM_BYTES - 1)) begin
            state_d = StResp;
          end else if (GAP_CYCLES == 0) begin
            state_d = StStart;
          end else begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StStart;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.blk_ready   = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.rsp_valid   = (state_q == StResp);
  assign bus.rsp_data    = rsp_q;
  assign bus.spi_start   = (state_q == StStart);
  assign bus.spi_tx      = tx_q[BlkW-1 -: 8];
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_spi_block_sequencer.sv
module tb_spi_block_sequencer;
  localparam int unsigned NB = 16;
  localparam int unsigned GA = 2;
  localparam int unsigned GB = 0;
  localparam int unsigned TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_block_sequencer_if #(.NUM_BYTES(NB)) a ();
  spi_block_sequencer_if #(.NUM_BYTES(NB)) b ();

  spi_block_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(GA), .TIMEOUT(TO)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  spi_block_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(GB), .TIMEOUT(TO)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // SPI byte master model A: done T negedges after start, rx = tx ^ xor_a.
  int          t_a = 16, stall_a = -1;
  logic [7:0]  xor_a = 8'h00, tx_a = 8'h00;
  bit          spur_a = 1'b0, spur_gap_a = 1'b0;
  int          cnt_a = 0, nbyte_a = 0, starts_a = 0, accs_a = 0;
  int          acc_cyc_a = 0, start_cyc_a = 0, done_cyc_a = -10, rsp_cyc_a = 0;
  logic        rv_prev_a = 1'b0;
  logic [127:0] tx_log_a = '0;

  // Model B: plain loopback.
  int          t_b = 5;
  logic [7:0]  tx_b = 8'h00;
  int          cnt_b = 0, nbyte_b = 0, acc_cyc_b = 0, done_cyc_b = -10, rsp_cyc_b = 0;
  logic        rv_prev_b = 1'b0;

  // Cycle index = negedge count; all events are sampled here, away from posedge.
  always @(negedge clk) begin
    cyc++;
    if (a.blk_valid && a.blk_ready) begin
      acc_cyc_a = cyc; accs_a++; nbyte_a = 0; tx_log_a = '0;
    end
    if (a.rsp_valid && !rv_prev_a) rsp_cyc_a = cyc;
    rv_prev_a = a.rsp_valid;
    a.spi_done = 1'b0;
    if (rst) cnt_a = 0;
    else if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin
        a.spi_done = 1'b1; a.spi_rx = tx_a ^ xor_a; done_cyc_a = cyc;
      end
    end
    if (spur_a || (spur_gap_a && done_cyc_a == cyc - 1)) begin
      a.spi_done = 1'b1; a.spi_rx = 8'hee;
    end
    if (a.spi_start) begin
      if (nbyte_a > 0) chk("gap_a", 128'(cyc - done_cyc_a), 128'(GA + 1));
      starts_a++; start_cyc_a = cyc; tx_a = a.spi_tx;
      tx_log_a = {tx_log_a[119:0], a.spi_tx};
      cnt_a = (nbyte_a == stall_a) ? 0 : t_a;
      nbyte_a++;
    end

    if (b.blk_valid && b.blk_ready) begin acc_cyc_b = cyc; nbyte_b = 0; end
    if (b.rsp_valid && !rv_prev_b) rsp_cyc_b = cyc;
    rv_prev_b = b.rsp_valid;
    b.spi_done = 1'b0;
    if (rst) cnt_b = 0;
    else if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin b.spi_done = 1'b1; b.spi_rx = tx_b; done_cyc_b = cyc; end
    end
    if (b.spi_start) begin
      if (nbyte_b > 0) chk("gap_b", 128'(cyc - done_cyc_b), 128'(GB + 1));
      tx_b = b.spi_tx; cnt_b = t_b; nbyte_b++;
    end
  end

  task automatic send_a(input logic [127:0] d);
    int k = 0;
    @(posedge clk); #1;
    while (!a.blk_ready && k < 3000) begin @(posedge clk); #1; k++; end
    if (!a.blk_ready) chk("send_a_ready", 128'(a.blk_ready), 128'(1));
    a.blk_valid = 1'b1; a.blk_data = d;
    @(posedge clk); #1;
    a.blk_valid = 1'b0;
  endtask

  task automatic wait_rsp_a(input int budget);
    int k = 0;
    while (!a.rsp_valid && k < budget) begin @(negedge clk); #1; k++; end
    chk("rsp_a_seen", 128'(a.rsp_valid), 128'(1));
  endtask

  task automatic take_rsp_a;
    @(posedge clk); #1; a.rsp_ready = 1'b1;
    @(posedge clk); #1; a.rsp_ready = 1'b0;
    chk("rsp_a_drop", 128'(a.rsp_valid), 128'(0));
    chk("rsp_a_idle", 128'(a.blk_ready), 128'(1));
  endtask

  logic [127:0] blk;
  int s0, acc0, bad, k;

  initial begin
    a.blk_valid = 1'b0; a.blk_data = '0; a.rsp_ready = 1'b0; a.spi_rx = '0; a.spi_done = 1'b0;
    b.blk_valid = 1'b0; b.blk_data = '0; b.rsp_ready = 1'b0; b.spi_rx = '0; b.spi_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_in", 128'(a.busy), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 128'(a.blk_ready), 128'(1));
    chk("rst_rsp_valid", 128'(a.rsp_valid), 128'(0));
    chk("rst_rsp_data", a.rsp_data, 128'(0));
    chk("rst_start", 128'(a.spi_start), 128'(0));
    chk("rst_tx", 128'(a.spi_tx), 128'(0));
    chk("rst_busy", 128'(a.busy), 128'(0));
    chk("rst_err", 128'(a.err_timeout), 128'(0));

    // Loopback, T=16, G=2: accept..rsp_valid inclusive = 16*19-2+2.
    blk = 128'h000102030405060708090a0b0c0d0e0f;
    t_a = 16; xor_a = 8'h00; s0 = starts_a; acc0 = accs_a;
    send_a(blk);
    wait_rsp_a(1000);
    chk("t1_data", a.rsp_data, blk);
    chk("t1_err", 128'(a.err_timeout), 128'(0));
    chk("t1_starts", 128'(starts_a - s0), 128'(16));
    chk("t1_txseq", tx_log_a, blk);
    chk("t1_lat", 128'(rsp_cyc_a - acc_cyc_a + 1), 128'(304));
    chk("t1_busy", 128'(a.busy), 128'(1));

    // Response held 50 cycles with blk_valid pending.
    s0 = starts_a; acc0 = accs_a; bad = 0;
    a.blk_valid = 1'b1; a.blk_data = ~blk;
    repeat (50) begin
      @(negedge clk); #1;
      if (a.rsp_valid !== 1'b1 || a.rsp_data !== blk || a.blk_ready !== 1'b0) bad++;
    end
    a.blk_valid = 1'b0;
    chk("t4_hold", 128'(bad), 128'(0));
    chk("t4_nostart", 128'(starts_a - s0), 128'(0));
    chk("t4_noacc", 128'(accs_a - acc0), 128'(0));
    take_rsp_a();

    // Non-loopback data, T=3: 16*6-2+2.
    blk = 128'hfedcba9876543210_0f1e2d3c4b5a6978;
    t_a = 3; xor_a = 8'ha5;
    send_a(blk);
    wait_rsp_a(400);
    chk("p2_data", a.rsp_data, blk ^ {16{8'ha5}});
    chk("p2_lat", 128'(rsp_cyc_a - acc_cyc_a + 1), 128'(96));
    take_rsp_a();
    xor_a = 8'h00;

    // Zero gap instance, T=5: 16*6-0+2.
    blk = 128'h0123456789abcdef_fedcba9876543210;
    @(posedge clk); #1; b.blk_valid = 1'b1; b.blk_data = blk;
    @(posedge clk); #1; b.blk_valid = 1'b0;
    k = 0;
    while (!b.rsp_valid && k < 400) begin @(negedge clk); #1; k++; end
    chk("b_seen", 128'(b.rsp_valid), 128'(1));
    chk("b_data", b.rsp_data, blk);
    chk("b_lat", 128'(rsp_cyc_b - acc_cyc_b + 1), 128'(98));
    @(posedge clk); #1; b.rsp_ready = 1'b1;
    @(posedge clk); #1; b.rsp_ready = 1'b0;
    chk("b_drop", 128'(b.rsp_valid), 128'(0));

    // Byte 5 never completes.
    blk = 128'h112233445566778899aabbccddeeff00;
    t_a = 4; stall_a = 5; s0 = starts_a;
    send_a(blk);
    wait_rsp_a(1500);
    chk("t3_err", 128'(a.err_timeout), 128'(1));
    chk("t3_data", a.rsp_data, {blk[127:88], 88'h0});
    chk("t3_starts", 128'(starts_a - s0), 128'(6));
    chk("t3_to_lat", 128'(rsp_cyc_a - start_cyc_a), 128'(TO + 1));
    take_rsp_a();
    chk("t3_sticky", 128'(a.err_timeout), 128'(1));
    stall_a = -1; t_a = 2;
    blk = ~blk;
    send_a(blk);
    chk("t3_err_clr", 128'(a.err_timeout), 128'(0));
    wait_rsp_a(300);
    chk("t3_next_data", a.rsp_data, blk);
    take_rsp_a();

    // Reset inside WAIT of byte 7.
    blk = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    t_a = 20;
    send_a(blk);
    k = 0;
    while (nbyte_a != 8 && k < 2000) begin @(negedge clk); #1; k++; end
    repeat (3) begin @(negedge clk); #1; end
    chk("t5_pre_busy", 128'(a.busy), 128'(1));
    rst = 1'b1; #1;
    chk("t5_busy", 128'(a.busy), 128'(0));
    chk("t5_ready", 128'(a.blk_ready), 128'(1));
    chk("t5_rsp_valid", 128'(a.rsp_valid), 128'(0));
    chk("t5_rsp_data", a.rsp_data, 128'(0));
    chk("t5_start", 128'(a.spi_start), 128'(0));
    chk("t5_tx", 128'(a.spi_tx), 128'(0));
    chk("t5_err", 128'(a.err_timeout), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    s0 = starts_a;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_quiet", 128'(starts_a - s0), 128'(0));
    blk = 128'h0f0e0d0c0b0a09080706050403020100;
    t_a = 4; s0 = starts_a;
    send_a(blk);
    wait_rsp_a(400);
    chk("t5_txseq", tx_log_a, blk);
    chk("t5_data", a.rsp_data, blk);
    chk("t5_starts", 128'(starts_a - s0), 128'(16));
    take_rsp_a();

    // Spurious spi_done in IDLE.
    s0 = starts_a;
    @(posedge clk); #1; spur_a = 1'b1;
    @(posedge clk); #1; spur_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_busy", 128'(a.busy), 128'(0));
    chk("t6_idle_data", a.rsp_data, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("t6_idle_start", 128'(starts_a - s0), 128'(0));

    // Spurious spi_done in every GAP plus blk_valid held while busy: 16*9-2+2.
    blk = 128'h8899aabbccddeeff0011223344556677;
    t_a = 6; spur_gap_a = 1'b1; acc0 = accs_a;
    send_a(blk);
    a.blk_valid = 1'b1; a.blk_data = ~blk;
    wait_rsp_a(600);
    a.blk_valid = 1'b0;
    chk("t6_data", a.rsp_data, blk);
    chk("t6_txseq", tx_log_a, blk);
    chk("t6_accs", 128'(accs_a - acc0), 128'(1));
    chk("t6_lat", 128'(rsp_cyc_a - acc_cyc_a + 1), 128'(144));
    chk("t6_err", 128'(a.err_timeout), 128'(0));
    spur_gap_a = 1'b0;
    take_rsp_a();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
